// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC scrubber and its Hamming decoder.
//   - code_width(): stored codeword width (data + Hamming parity + overall parity)
//   - is_parity_pos(): true for codeword bit indices 2^k-1 (Hamming parity slots)
//   - scrub_state_e: scrubber FSM states
//   - err_class_e: decoder classification of a read codeword
package ecc_pkg;

    function automatic int code_width(input int data_w, input int parity_len);
        return data_w + parity_len + 1;
    endfunction

    // Bit index i holds a Hamming parity bit when its 1-based position (i+1)
    // is a power of two.
    function automatic bit is_parity_pos(input int idx);
        return ((idx + 1) & idx) == 0;
    endfunction

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_PARITY_LENGTH = 6;
    localparam int DEF_CODE_WIDTH    = code_width(DEF_DATA_WIDTH, DEF_PARITY_LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD,
        RDW,
        CHK,
        WR,
        NXT
    } scrub_state_e;

    typedef enum logic [1:0] {
        CLEAN,
        CE,
        CE_PAR,
        UE
    } err_class_e;

endpackage

// File: rtl/ecc_hamming_decoder.sv
// ecc_hamming_decoder: combinational SEC-DED check of one stored codeword.
// Layout: Hamming parity at bit indices 2^k-1, data in the remaining indices
// LSB-first, overall even parity in the MSB.
// Ports:
//   codeword   in   CODE_WIDTH     codeword to check
//   syndrome   out  PARITY_LENGTH  1-based position of a single error, 0 if none
//   parity_err out  1              overall parity mismatch
//   corrected  out  CODE_WIDTH     codeword with a correctable error repaired
//   err_class  out  err_class_e    CLEAN / CE / CE_PAR / UE
module ecc_hamming_decoder
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int PARITY_LENGTH = 6,
    parameter int CODE_WIDTH    = code_width(DATA_WIDTH, PARITY_LENGTH)
) (
    input  logic [CODE_WIDTH-1:0]    codeword,
    output logic [PARITY_LENGTH-1:0] syndrome,
    output logic                     parity_err,
    output logic [CODE_WIDTH-1:0]    corrected,
    output err_class_e               err_class
);

    always_comb begin
        syndrome   = '0;
        parity_err = ^codeword;
        corrected  = codeword;
        err_class  = CLEAN;

        // XOR of the 1-based positions of all set bits; zero for a valid word.
        for (int i = 0; i < CODE_WIDTH - 1; i++) begin
            if (codeword[i]) begin
                syndrome = syndrome ^ PARITY_LENGTH'(i + 1);
            end
        end

        if (syndrome == '0) begin
            if (parity_err) begin
                err_class = CE_PAR;
                corrected[CODE_WIDTH-1] = ~codeword[CODE_WIDTH-1];
            end
        end else if (!parity_err || (int'(syndrome) > CODE_WIDTH - 1)) begin
            // Even number of flips, or a position that does not exist.
            err_class = UE;
        end else begin
            err_class = CE;
            for (int i = 0; i < CODE_WIDTH - 1; i++) begin
                if (int'(syndrome) == i + 1) begin
                    corrected[i] = ~codeword[i];
                end
            end
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber for the ECC-protected shared memory.
// Walks every word address, reads and checks it, writes back corrected
// single-bit errors and counts corrected / uncorrectable errors.
// Optional macro ECC_SCRUB_UE_LOG_EN adds ue_addr / ue_irq.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   scrub_en          level enable
//   mem_req/we/addr/wdata, mem_gnt   arbiter request interface (lowest priority)
//   mem_rvalid/rdata  read return
//   ce_count/ue_count saturating error counters
//   pass_done         pulse when the address pointer wraps to 0
//   busy              high outside IDLE and WAIT
//   ue_addr, ue_irq   (ECC_SCRUB_UE_LOG_EN) last uncorrectable address, detect pulse
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int PARITY_LENGTH = 6,
    parameter int CODE_WIDTH    = code_width(DATA_WIDTH, PARITY_LENGTH),
    parameter int INTERVAL      = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CODE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [CODE_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  ce_count,
    output logic [CNT_WIDTH-1:0]  ue_count,
    output logic                  pass_done,
    output logic                  busy
`ifdef ECC_SCRUB_UE_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] ue_addr,
    output logic                  ue_irq
`endif
);

    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0]         IVL_LOAD = IW'(INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    scrub_state_e                 state, state_nxt;
    logic [IW-1:0]                ivl_cnt;
    logic [ADDR_WIDTH-1:0]        ptr;
    logic [CODE_WIDTH-1:0]        rd_cw;
    logic [CODE_WIDTH-1:0]        wr_cw;
    logic [CNT_WIDTH-1:0]         ce_cnt, ue_cnt;

    logic [PARITY_LENGTH-1:0]     dec_syndrome;
    logic                         dec_parity_err;
    logic [CODE_WIDTH-1:0]        dec_corrected;
    err_class_e                   dec_class;
    logic                         chk_clean, chk_ue, chk_ce;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    ecc_hamming_decoder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PARITY_LENGTH (PARITY_LENGTH),
        .CODE_WIDTH    (CODE_WIDTH)
    ) u_dec (
        .codeword   (rd_cw),
        .syndrome   (dec_syndrome),
        .parity_err (dec_parity_err),
        .corrected  (dec_corrected),
        .err_class  (dec_class)
    );

    // CE and CE_PAR both need a write-back; everything else skips to NXT.
    assign chk_clean = (dec_syndrome == '0) && !dec_parity_err;
    assign chk_ue    = (dec_class == UE);
    assign chk_ce    = !chk_clean && !chk_ue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        pass_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (scrub_en) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b0;
                if (!scrub_en)           state_nxt = IDLE;
                else if (ivl_cnt == '0)  state_nxt = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = RDW;
            end
            RDW: begin
                if (mem_rvalid) state_nxt = CHK;
            end
            CHK: begin
                state_nxt = chk_ce ? WR : NXT;
            end
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) state_nxt = NXT;
            end
            NXT: begin
                pass_done = (ptr == ADDR_MAX);
                state_nxt = scrub_en ? WAIT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr  = ptr;
    assign mem_wdata = wr_cw;
    assign ce_count  = ce_cnt;
    assign ue_count  = ue_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivl_cnt <= '0;
            ptr     <= '0;
            ce_cnt  <= '0;
            ue_cnt  <= '0;
            wr_cw   <= '0;
        end else begin
            case (state)
                IDLE: if (scrub_en) ivl_cnt <= IVL_LOAD;
                WAIT: if (ivl_cnt != '0) ivl_cnt <= ivl_cnt - IW'(1);
                CHK: begin
                    if (chk_ce) ce_cnt <= sat_inc(ce_cnt);
                    if (chk_ue) ue_cnt <= sat_inc(ue_cnt);
                    wr_cw <= dec_corrected;
                end
                NXT: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (scrub_en) ivl_cnt <= IVL_LOAD;
                end
                default: ;
            endcase
        end
    end

    // Read data capture; only accepted while a read is outstanding, so a
    // late rvalid after reset is dropped.
    always_ff @(posedge clk) begin
        if (state == RDW && mem_rvalid) begin
            rd_cw <= mem_rdata;
        end
    end

`ifdef ECC_SCRUB_UE_LOG_EN
    logic [ADDR_WIDTH-1:0] ue_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ue_addr_q <= '0;
        end else if (state == CHK && chk_ue) begin
            ue_addr_q <= ptr;
        end
    end

    assign ue_addr = ue_addr_q;
    assign ue_irq  = (state == CHK) && chk_ue;
`else
    // Default build: uncorrectable errors are only counted.
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
module tb_ecc_scrub_ctrl;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int PL     = 6;
    localparam int CW     = DW + PL + 1;
    localparam int IV     = 4;
    localparam int NW     = 4;
    localparam int NWORDS = 1 << AW;
    localparam int CMAX   = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          scrub_en;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata, mem_rdata;
    logic [NW-1:0] ce_count, ue_count;
    logic          pass_done, busy;
`ifdef ECC_SCRUB_UE_LOG_EN
    logic [AW-1:0] ue_addr;
    logic          ue_irq;
`endif

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .PARITY_LENGTH (PL),
        .CODE_WIDTH    (CW),
        .INTERVAL      (IV),
        .CNT_WIDTH     (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scrub_en   (scrub_en),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ce_count   (ce_count),
        .ue_count   (ue_count),
        .pass_done  (pass_done),
        .busy       (busy)
`ifdef ECC_SCRUB_UE_LOG_EN
        ,
        .ue_addr    (ue_addr),
        .ue_irq     (ue_irq)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder built directly from the layout rule.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int j;
        bit p;
        c = '0;
        j = 0;
        for (int i = 0; i < CW - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                c[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < PL; k++) begin
            p = 1'b0;
            for (int i = 0; i < CW - 1; i++) begin
                if ((((i + 1) >> k) & 1) != 0) p = p ^ c[i];
            end
            c[(1 << k) - 1] = p;
        end
        c[CW-1] = ^c[CW-2:0];
        return c;
    endfunction

    // Memory and expectation model: golden holds the clean codeword of each
    // word, mem holds what is stored; the flip count between them decides
    // the expected outcome of a scrub.
    logic [CW-1:0] golden [NWORDS];
    logic [CW-1:0] mem    [NWORDS];
    bit            used   [NWORDS];

    int      exp_ptr = 0, exp_ce = 0, exp_ue = 0, cur_addr = 0;
    bit      wr_pending = 0, cur_ue = 0;
    bit      rv_pend = 0;
    int      rv_cnt = 0, rv_addr = 0, rv_force = -1;
    bit      req_wait = 0, hold_we = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [CW-1:0] hold_wdata = '0;
    int      hold_cnt = 0, hold_rd_addr = -1;
    bit      hold_wr = 0, drop_in_wr = 0;
    int      wraps_seen = 0, wraps_exp = 0, rd_cnt = 0, wr_cnt = 0;
    bit      prev_busy = 0, had_busy = 0, run_ok = 0;
    int      run = 0;
    int      irq_seen = 0, exp_irq = 0;
    bit      irq_prev = 0;

    task automatic cycle();
        int flips;
        @(negedge clk);

        if (req_wait) begin
            check_val("req_held", mem_req, 1);
            check_val("addr_held", mem_addr, hold_addr);
            check_val("we_held", mem_we, hold_we);
            if (hold_we) check_val("wdata_held", mem_wdata, hold_wdata);
        end
        if (pass_done) begin
            wraps_seen++;
            check_val("wrap_addr", cur_addr, NWORDS - 1);
            check_val("wrap_after_wr", wr_pending, 0);
        end
`ifdef ECC_SCRUB_UE_LOG_EN
        if (irq_prev) check_val("ue_addr", ue_addr, cur_addr);
        irq_prev = ue_irq;
        if (ue_irq) begin
            irq_seen++;
            check_val("irq_is_ue", cur_ue, 1);
        end
`endif
        // Idle gap between two scrubs while enabled must be INTERVAL cycles.
        if (busy) begin
            if (!prev_busy && had_busy && run_ok) check_val("interval", run, IV);
            had_busy = 1;
            run      = 0;
            run_ok   = 1;
        end else begin
            run++;
            if (!scrub_en) run_ok = 0;
        end
        prev_busy = busy;

        if (rv_pend && rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[rv_addr];
            rv_pend    = 0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = CW'({$urandom(), $urandom()});
            if (rv_pend) rv_cnt--;
        end

        if (mem_req) begin
            if (hold_cnt == 0 && !req_wait) begin
                if (!mem_we && int'(mem_addr) == hold_rd_addr) begin
                    hold_cnt     = 20;
                    hold_rd_addr = -1;
                end else if (mem_we && hold_wr) begin
                    hold_cnt = 20;
                    hold_wr  = 0;
                    if (drop_in_wr) begin
                        scrub_en   = 1'b0;
                        drop_in_wr = 0;
                    end
                end
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                mem_gnt = 1'b0;
            end else begin
                mem_gnt = ($urandom_range(0, 3) != 0);
            end

            if (mem_gnt) begin
                req_wait = 0;
                if (!mem_we) begin
                    check_val("rd_addr", mem_addr, exp_ptr);
                    check_val("rd_no_missed_wr", wr_pending, 0);
                    check_val("ce_count", ce_count, exp_ce);
                    check_val("ue_count", ue_count, exp_ue);
                    cur_addr = exp_ptr;
                    exp_ptr  = (exp_ptr + 1) % NWORDS;
                    flips    = $countones(mem[cur_addr] ^ golden[cur_addr]);
                    cur_ue   = (flips == 2);
                    if (flips == 1) begin
                        wr_pending = 1;
                        exp_ce     = (exp_ce < CMAX) ? exp_ce + 1 : CMAX;
                    end
                    if (flips == 2) begin
                        exp_ue = (exp_ue < CMAX) ? exp_ue + 1 : CMAX;
                        exp_irq++;
                    end
                    if (cur_addr == NWORDS - 1) wraps_exp++;
                    rv_pend  = 1;
                    rv_addr  = int'(mem_addr);
                    rv_cnt   = (rv_force >= 0) ? rv_force : int'($urandom_range(0, 2));
                    rv_force = -1;
                    rd_cnt++;
                end else begin
                    check_val("wr_expected", wr_pending, 1);
                    check_val("wr_addr", mem_addr, cur_addr);
                    check_val("wr_data", mem_wdata, golden[cur_addr]);
                    check_val("wr_ce_count", ce_count, exp_ce);
                    mem[mem_addr] = mem_wdata;
                    wr_pending = 0;
                    wr_cnt++;
                end
            end else begin
                req_wait   = 1;
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end
        end else begin
            req_wait = 0;
            mem_gnt  = ($urandom_range(0, 1) != 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_req"}, mem_req, 0);
        check_val({tag, "_we"}, mem_we, 0);
        check_val({tag, "_addr"}, mem_addr, 0);
        check_val({tag, "_wdata"}, mem_wdata, 0);
        check_val({tag, "_ce"}, ce_count, 0);
        check_val({tag, "_ue"}, ue_count, 0);
        check_val({tag, "_pass"}, pass_done, 0);
        check_val({tag, "_busy"}, busy, 0);
`ifdef ECC_SCRUB_UE_LOG_EN
        check_val({tag, "_ueaddr"}, ue_addr, 0);
        check_val({tag, "_ueirq"}, ue_irq, 0);
`endif
    endtask

    function automatic int pick_free();
        int a;
        do a = int'($urandom_range(0, NWORDS - 1)); while (used[a]);
        used[a] = 1;
        return a;
    endfunction

    initial begin
        int a, b0, b1, n, bad;

        rst        = 1'b1;
        scrub_en   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        for (int i = 0; i < NWORDS; i++) begin
            golden[i] = encode($urandom());
            mem[i]    = golden[i];
            used[i]   = 0;
        end
        mem[5] = mem[5] ^ (CW'(1) << 2);
        mem[9] = mem[9] ^ (CW'(1) << 2) ^ (CW'(1) << 4);
        mem[3] = mem[3] ^ (CW'(1) << 38);
        used[3] = 1; used[5] = 1; used[9] = 1; used[20] = 1;
        for (int i = 0; i < 30; i++) begin
            a = pick_free();
            mem[a] = mem[a] ^ (CW'(1) << $urandom_range(0, CW - 1));
        end
        for (int i = 0; i < 20; i++) begin
            a  = pick_free();
            b0 = int'($urandom_range(0, CW - 1));
            do b1 = int'($urandom_range(0, CW - 1)); while (b1 == b0);
            mem[a] = mem[a] ^ (CW'(1) << b0) ^ (CW'(1) << b1);
        end

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (3) cycle();
        check_val("idle_disabled_busy", busy, 0);
        check_val("idle_disabled_req", mem_req, 0);

        // Full pass with long grant stalls on one read and one write.
        hold_rd_addr = 20;
        hold_wr      = 1;
        scrub_en     = 1'b1;
        for (int i = 0; i < 8000 && wraps_seen == 0; i++) cycle();
        check_val("pass1_done", wraps_seen, 1);
        bad = 0;
        for (int i = 0; i < NWORDS; i++) begin
            if ($countones(mem[i] ^ golden[i]) == 1) bad++;
        end
        check_val("pass1_healed", bad, 0);
        check_val("pass1_ce_sat", ce_count, exp_ce);
        check_val("pass1_ue_sat", ue_count, exp_ue);

        // Disable during a stalled write: the write completes, then IDLE.
        mem[2]     = mem[2] ^ (CW'(1) << 7);
        hold_wr    = 1;
        drop_in_wr = 1;
        n = wr_cnt;
        for (int i = 0; i < 400 && wr_cnt == n; i++) cycle();
        check_val("drop_wr_done", wr_cnt, n + 1);
        repeat (10) cycle();
        check_val("drop_idle_busy", busy, 0);
        check_val("drop_idle_req", mem_req, 0);

        // Reset while waiting for read data, then a late rvalid.
        scrub_en = 1'b1;
        rv_force = 6;
        n = rd_cnt;
        for (int i = 0; i < 200 && rd_cnt == n; i++) cycle();
        check_val("rdw_read_issued", rd_cnt, n + 1);
        cycle();
        check_val("rdw_busy", busy, 1);
        check_val("rdw_req", mem_req, 0);
        #1;
        rst      = 1'b1;
        scrub_en = 1'b0;
        #1;
        check_zero("async_rst");
        if (cur_ue) exp_irq--;
        if (cur_addr == NWORDS - 1) wraps_exp--;
        exp_ptr    = 0;
        exp_ce     = 0;
        exp_ue     = 0;
        wr_pending = 0;
        cur_ue     = 0;
        req_wait   = 0;
        hold_cnt   = 0;
        had_busy   = 0;
        irq_prev   = 0;
        cycle();
        cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check_zero("late_rvalid");

        // Restart from address 0 with cleared counters.
        scrub_en = 1'b1;
        n = rd_cnt;
        for (int i = 0; i < 300 && rd_cnt < n + 3; i++) cycle();
        check_val("restart_reads", rd_cnt, n + 3);
        repeat (20) cycle();

        check_val("pass_done_count", wraps_seen, wraps_exp);
`ifdef ECC_SCRUB_UE_LOG_EN
        check_val("ue_irq_count", irq_seen, exp_irq);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background memory scrubber for the ECC-protected shared memory bank of the CGRA.
- Periodically reads each codeword and checks it with the SEC-DED Hamming decoder.
- Writes back the corrected codeword when a single-bit error is found.
- Logs double-bit (uncorrectable) errors.
- Acts as one requester on the shared-memory arbiter, with the lowest priority.

Parameters:
ADDR_WIDTH, 8, word address width; scrub range is 0 .. 2^ADDR_WIDTH-1
DATA_WIDTH, 32, payload width
PARITY_LENGTH, 6, Hamming parity bits for DATA_WIDTH
CODE_WIDTH, 39, stored codeword width = DATA_WIDTH+PARITY_LENGTH+1 (overall parity in MSB)
INTERVAL, 1024, idle cycles between consecutive word scrubs (must be >=1)
CNT_WIDTH, 16, width of the error counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
scrub_en  in  1  enables scrubbing; level-sensitive
mem_req  out  1  request to the shared-memory arbiter
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  CODE_WIDTH  corrected codeword for write-back
mem_gnt  in  1  arbiter grant; the access is accepted in the cycle where mem_req && mem_gnt
mem_rvalid  in  1  read data valid; arrives 1 or more cycles after the read grant
mem_rdata  in  CODE_WIDTH  read codeword
ce_count  out  CNT_WIDTH  corrected-error count, saturating
ue_count  out  CNT_WIDTH  uncorrectable-error count, saturating
pass_done  out  1  one-cycle pulse when the address wraps from max back to 0
busy  out  1  high in any state other than IDLE and WAIT

Behaviour:
Reset values:
- All outputs are 0. The FSM is in IDLE, the address pointer is 0 and the interval counter is 0.
- Reset asserted mid-operation drops mem_req immediately (asynchronous). Any outstanding rvalid is ignored after reset.

FSM states:
- IDLE: if scrub_en, load the interval counter with INTERVAL-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0 go to RD. If scrub_en goes low, return to IDLE.
- RD: mem_req=1, mem_we=0, mem_addr=ptr. Hold all three stable until the grant, then go to RDW.
- RDW: wait for mem_rvalid, then register mem_rdata into the decoder input and go to CHK.
- CHK: one cycle. Register the decoder result (syndrome, overall parity) and apply the classification:
  - syndrome=0, parity ok: clean; go to NXT.
  - syndrome!=0, parity error: single error; ce_count+1; go to WR with the corrected codeword.
  - syndrome=0, parity error: error in the overall-parity bit only; ce_count+1; go to WR with the parity bit flipped.
  - syndrome!=0, parity ok: double error; ue_count+1; no write-back; go to NXT.
  - Out-of-range syndrome (position > CODE_WIDTH-1): treated as uncorrectable.
- WR: mem_req=1, mem_we=1, mem_wdata=corrected codeword, same address. Hold until the grant, then go to NXT.
- NXT: ptr+1, wrapping at 2^ADDR_WIDTH-1 to 0. On wrap, pulse pass_done in this cycle. Go to WAIT if scrub_en is high, else IDLE.

Latency: minimum for a clean word after WAIT is RD(1) + RDW(>=1) + CHK(1) + NXT(1).

Rules:
- scrub_en deasserted during RD/RDW/CHK/WR: the current word completes (the handshake is never abandoned), then go to IDLE.
- Counters saturate at all-ones and never wrap.
- mem_req never deasserts before its grant.
- Codeword bit order matches the encoder layout:
  - parity bits at positions 2^k-1;
  - data filling the remaining positions LSB-first;
  - overall even parity at bit CODE_WIDTH-1.

Optional Feature:
ECC_SCRUB_UE_LOG_EN
- Defined: adds output ue_addr (ADDR_WIDTH, address of the most recent uncorrectable word, reset 0) and output ue_irq (one-cycle pulse in the CHK cycle that detects a double error).
- Undefined: neither port exists and no log register is built.

Decomposition:
Shared package ecc_pkg:
- CODE_WIDTH derivation;
- parity position constants;
- the FSM state enum (IDLE, WAIT, RD, RDW, CHK, WR, NXT);
- the error-class enum (CLEAN, CE, CE_PAR, UE).

One natural sub-module, ecc_hamming_decoder:
- purely combinational;
- input codeword;
- outputs: syndrome, overall parity error, corrected codeword, error class.

Test Plan:
- scrub_en=1, INTERVAL=4, memory all clean, rvalid 1 cycle after grant -> 4 idle cycles between reads, no writes, counts stay 0, pass_done pulses once after address 255.
- Word 5 has data bit 0 flipped (codeword bit 2) -> CHK flags CE, WR to address 5 with the corrected codeword, ce_count=1.
- Word 9 has codeword bits 2 and 4 flipped -> ue_count=1, no write issued; with ECC_SCRUB_UE_LOG_EN, ue_addr=9 and ue_irq pulses once.
- Word 3 has only bit 38 flipped -> classified CE_PAR, write-back with bit 38 restored, ce_count=1.
- mem_gnt held low for 20 cycles in RD and WR -> mem_req, mem_addr and mem_wdata are stable throughout; scrub_en dropped during WR -> the write completes, then IDLE.
- rst pulsed while in RDW, then a late rvalid -> all outputs are 0, FSM in IDLE, the late rvalid is ignored; ce_count preloaded near saturation (0xFFFF) plus one more CE -> stays 0xFFFF.
